ft245_sync_phy: RTL



---
 rtl/ft245_sync_phy.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ft245_sync_phy.sv
// rtl/ft245_sync_phy.sv - FT245 synchronous-FIFO bus master with bounded read/write bursts.
// Optional SIWU# idle pulse generator enabled by `define SEND_IMMEDIATE_EN.
module ft245_sync_phy #(
  parameter int RD_BURST_MAX   = 64,
  parameter int WR_BURST_MAX   = 512,
  parameter int SI_IDLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_en,
  output logic       output_enable_ftd_n,
  input  logic       ftd_rx_fifo_empty,
  output logic       read_rx_fifo_ftd_n,
  input  logic       ftd_tx_fifo_full,
  output logic       write_tx_fifo_ftd_n,
  output logic       send_immediately_ftd_n,
  output logic [7:0] ds_stream,
  output logic       ds_valid,
  input  logic [7:0] us_stream,
  input  logic       us_valid,
  output logic       us_ready
);

  typedef enum logic [2:0] {IDLE, RD_OE, RD_BURST, TURN, WR_BURST} state_t;

  localparam logic [8:0]  RD_MAX = 9'(RD_BURST_MAX);
  localparam logic [10:0] WR_MAX = 11'(WR_BURST_MAX);

  if (RD_BURST_MAX < 1 || RD_BURST_MAX > 255 || WR_BURST_MAX < 1 ||
      WR_BURST_MAX > 1023 || SI_IDLE_CYCLES < 1) begin : g_bad_params
    $error("ft245_sync_phy: parameter out of range");
  end

  state_t      state;
  logic        last_wr;
  logic        hold_full;
  logic [8:0]  rd_cnt;
  logic [10:0] wr_cnt;

  logic rd_pend, wr_pend, pick_rd, pick_wr;
  logic rd_xfer, rd_done, wr_xfer, wr_load, hold_next;

  always_comb begin
    rd_pend   = !ftd_rx_fifo_empty;
    wr_pend   = (us_valid || hold_full) && !ftd_tx_fifo_full && (run || hold_full);
    pick_rd   = rd_pend && (last_wr || !wr_pend);
    pick_wr   = wr_pend && !pick_rd;
    rd_xfer   = (state == RD_BURST) && !read_rx_fifo_ftd_n && !ftd_rx_fifo_empty;
    rd_done   = (state == RD_BURST) &&
                (ftd_rx_fifo_empty || (rd_xfer && (rd_cnt + 9'd1 >= RD_MAX)));
    wr_xfer   = (state == WR_BURST) && !write_tx_fifo_ftd_n && !ftd_tx_fifo_full;
    // A byte leaving the holding register this edge frees it for a same-edge refill.
    us_ready  = (state == WR_BURST) && (wr_cnt < WR_MAX) && (!hold_full || wr_xfer);
    wr_load   = us_valid && us_ready;
    hold_next = wr_load || (hold_full && !wr_xfer);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      last_wr             <= 1'b1;
      hold_full           <= 1'b0;
      rd_cnt              <= '0;
      wr_cnt              <= '0;
      data_o              <= 8'h00;
      data_en             <= 1'b0;
      output_enable_ftd_n <= 1'b1;
      read_rx_fifo_ftd_n  <= 1'b1;
      write_tx_fifo_ftd_n <= 1'b1;
      ds_stream           <= 8'h00;
      ds_valid            <= 1'b0;
    end else begin
      ds_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_rd) begin
            state               <= RD_OE;
            output_enable_ftd_n <= 1'b0;
          end else if (pick_wr) begin
            state               <= WR_BURST;
            data_en             <= 1'b1;
            wr_cnt              <= '0;
            write_tx_fifo_ftd_n <= !hold_full;
          end
        end
        RD_OE: begin
          state              <= RD_BURST;
          read_rx_fifo_ftd_n <= 1'b0;
          rd_cnt             <= '0;
        end
        RD_BURST: begin
          if (rd_xfer) begin
            ds_stream <= data_i;
            ds_valid  <= 1'b1;
            rd_cnt    <= rd_cnt + 9'd1;
          end
          if (rd_done) begin
            read_rx_fifo_ftd_n  <= 1'b1;
            output_enable_ftd_n <= 1'b1;
            last_wr             <= 1'b0;
            state               <= TURN;
          end
        end
        TURN: state <= IDLE;
        WR_BURST: begin
          hold_full <= hold_next;
          if (wr_load) begin
            data_o <= us_stream;
            wr_cnt <= wr_cnt + 11'd1;
          end
          // Leave only with nothing held, so a stalled byte is never dropped.
          if (!hold_next) begin
            write_tx_fifo_ftd_n <= 1'b1;
            data_en             <= 1'b0;
            last_wr             <= 1'b1;
            state               <= TURN;
          end else begin
            write_tx_fifo_ftd_n <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEND_IMMEDIATE_EN
  localparam logic [15:0] SI_LAST = 16'(SI_IDLE_CYCLES - 1);

  logic [15:0] si_cnt;
  logic        si_armed;
  logic        oe_low_next;

  always_comb begin
    oe_low_next = (state == IDLE && pick_rd) || (state == RD_OE) ||
                  (state == RD_BURST && !rd_done);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      si_cnt                 <= '0;
      si_armed               <= 1'b0;
      send_immediately_ftd_n <= 1'b1;
    end else begin
      send_immediately_ftd_n <= 1'b1;
      if (wr_xfer) begin
        si_cnt   <= '0;
        si_armed <= 1'b1;
      end else begin
        if (si_cnt < SI_LAST) si_cnt <= si_cnt + 16'd1;
        // Deferred while a read holds OE# low; stays armed until the bus is free.
        if (si_armed && si_cnt >= SI_LAST && !oe_low_next) begin
          send_immediately_ftd_n <= 1'b0;
          si_armed               <= 1'b0;
        end
      end
    end
  end
`else
  assign send_immediately_ftd_n = 1'b1;
`endif

endmodule
